crc8_packet_receiver: RTL and testbench
=======================================

// Module: crc8_packet_receiver
// PURPOSE
//  Receive-side deframer for the application layer. Consumes the byte stream from the PHY, one byte per
//  byte_valid strobe. Assembles 4 payload bytes (MSB first) plus 1 trailing CRC byte into a 32-bit word.
//  Checks CRC8 (DVB-S2: poly 0xD5, init 0x00, MSB-first, no reflection, no final XOR).
//  Presents good words downstream on a valid/ready handshake and counts bad frames.
// PARAMETERS
//  ERR_W    8     width of saturating CRC-error counter
//  TIMEOUT  1024  inter-byte idle cycles before a partial frame is dropped (used only with RX_TIMEOUT_EN)
// PORTS
//  clk         in   1       single clock, all logic on posedge
//  rst_n       in   1       asynchronous, active-low reset
//  byte_in     in   8       received byte
//  byte_valid  in   1       byte_in valid this cycle
//  byte_sof    in   1       qualifies byte_valid: byte is first payload byte of a frame
//  byte_ready  out  1       receiver can accept a byte this cycle
//  pkt_data    out  32      checked payload, byte 0 in [31:24]
//  pkt_valid   out  1       pkt_data valid; held until pkt_ready
//  pkt_ready   in   1       downstream accepts pkt_data
//  crc_err     out  1       1-cycle pulse: frame completed with CRC mismatch
//  err_cnt     out  ERR_W   saturating count of crc_err pulses
//  timeout_err out  1       1-cycle pulse: partial frame dropped on timeout (tied 0 without RX_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: state=COLLECT, byte count=0, running crc=0x00, pkt_data=0, pkt_valid=0, crc_err=0, err_cnt=0,
//   timeout_err=0, byte_ready=1.
//  Accept = byte_valid & byte_ready. Bytes presented while byte_ready=0 are dropped; no flag.
//  COLLECT (byte_ready=1), cnt = 0..4:
//   - Accept at cnt 0..3: shift byte into payload reg; crc <= TABLE[crc ^ byte]; cnt++.
//   - Accept at cnt 4: compare byte with running crc.
//     Match    -> pkt_data <= payload, pkt_valid=1 next cycle, go HOLD.
//     Mismatch -> crc_err pulses next cycle, err_cnt++ (saturates at all-ones), stay COLLECT.
//     Either way: cnt=0, crc=0x00.
//   - Accept with byte_sof=1 at any cnt: discard partial frame, treat byte as payload byte 0
//     (cnt becomes 1, crc=TABLE[byte]). No error pulse.
//   - byte_sof is ignored when cnt=0 (byte is byte 0 anyway).
//  HOLD (byte_ready=0): pkt_valid=1, pkt_data stable.
//   - On pkt_valid & pkt_ready: pkt_valid=0 next cycle, go COLLECT with byte_ready=1 that cycle.
//   - pkt_ready=1 with pkt_valid=0 has no effect.
//  Latency: CRC byte accepted at edge N -> pkt_valid or crc_err high after edge N+1 -> min 1 cycle.
//  Throughput: 5 byte cycles + 1 cycle per word, if pkt_ready is held high.
//  Reset asserted mid-frame or in HOLD: returns to reset values immediately. Partial/held word is lost;
//   err_cnt is cleared.
// CONFIGURATION
//  RX_TIMEOUT_EN defined:
//   - Idle counter clears on every accepted byte and counts while in COLLECT with cnt in 1..4.
//   - When it reaches TIMEOUT: cnt=0, crc=0x00, timeout_err pulses 1 cycle. err_cnt is unaffected.
//   - The counter is held at 0 in HOLD and when cnt=0.
//   - A byte accepted on the same edge as expiry wins: it is processed normally and there is no timeout.
//  RX_TIMEOUT_EN undefined:
//   - No idle counter; a partial frame persists until more bytes or byte_sof arrive.
//   - timeout_err is constant 0 and TIMEOUT is unused.
// TESTING
//  1 Good frame, pkt_ready=1: bytes 00,00,00,01 (sof on first), then D5 -> pkt_data=0x0000_0001;
//    pkt_valid 1 cycle; crc_err=0.
//  2 Bad CRC: 00,00,00,FF then 00 (expected F9) -> crc_err one pulse, err_cnt 0->1, no pkt_valid.
//    Then 00,00,00,FF,F9 -> pkt_data=0x0000_00FF.
//  3 Backpressure: good frame with pkt_ready=0 for 10 cycles -> pkt_valid/pkt_data stable,
//    byte_ready=0, bytes during hold dropped; pkt_ready=1 -> one transfer, byte_ready=1 next cycle.
//  4 Resync: 12,34 then sof byte 00, then 00,00,01,D5 -> pkt_data=0x0000_0001; no crc_err.
//  5 Saturation (ERR_W=2): 5 bad frames -> err_cnt sequence 1,2,3,3,3.
//  6 RX_TIMEOUT_EN, TIMEOUT=8: 00,00 then 8 idle cycles -> timeout_err pulse.
//    Then 00,00,00,01,D5 -> good word 0x0000_0001. rst_n low mid-frame -> all outputs at reset values.

Source files
------------

// File: rtl/crc8_packet_receiver.sv
// CRC8 (poly 0xD5) checked 4-byte packet deframer with valid/ready output and saturating error count.
// Define RX_TIMEOUT_EN to drop partial frames after TIMEOUT idle cycles.
module crc8_packet_receiver #(
    parameter int ERR_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    input  logic             byte_sof,
    output logic             byte_ready,
    output logic [31:0]      pkt_data,
    output logic             pkt_valid,
    input  logic             pkt_ready,
    output logic             crc_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             timeout_err
);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [7:0]  crc;
    logic [31:0] payload;
    logic        accept;
    logic        expire;

    // One byte through the MSB-first CRC8 loop; equivalent to the 256-entry table lookup.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'hD5) : (c << 1);
        end
        return c;
    endfunction

    assign accept = byte_valid & byte_ready;

`ifdef RX_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_cnt;

    // An accepted byte on the expiry edge takes precedence, hence the !accept term.
    assign expire = (state == COLLECT) && (cnt != 3'd0) && !accept &&
                    (idle_cnt == IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= expire;
            if (accept || state != COLLECT || cnt == 3'd0 || expire)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign expire      = (TIMEOUT < 0);
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= COLLECT;
            cnt        <= 3'd0;
            crc        <= 8'h00;
            payload    <= 32'h0;
            pkt_data   <= 32'h0;
            pkt_valid  <= 1'b0;
            crc_err    <= 1'b0;
            err_cnt    <= '0;
            byte_ready <= 1'b1;
        end else begin
            crc_err <= 1'b0;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        if (byte_sof || cnt == 3'd0) begin
                            payload <= {payload[23:0], byte_in};
                            crc     <= crc8_step(8'h00, byte_in);
                            cnt     <= 3'd1;
                        end else if (cnt != 3'd4) begin
                            payload <= {payload[23:0], byte_in};
                            crc     <= crc8_step(crc, byte_in);
                            cnt     <= cnt + 3'd1;
                        end else begin
                            cnt <= 3'd0;
                            crc <= 8'h00;
                            if (byte_in == crc) begin
                                pkt_data   <= payload;
                                pkt_valid  <= 1'b1;
                                byte_ready <= 1'b0;
                                state      <= HOLD;
                            end else begin
                                crc_err <= 1'b1;
                                if (err_cnt != {ERR_W{1'b1}})
                                    err_cnt <= err_cnt + 1'b1;
                            end
                        end
                    end else if (expire) begin
                        cnt <= 3'd0;
                        crc <= 8'h00;
                    end
                end
                HOLD: begin
                    if (pkt_ready) begin
                        pkt_valid  <= 1'b0;
                        byte_ready <= 1'b1;
                        state      <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_crc8_packet_receiver.sv
// Directed testbench for crc8_packet_receiver (ERR_W=2, TIMEOUT=8); timeout checks follow RX_TIMEOUT_EN.
module tb_crc8_packet_receiver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_sof;
    logic        byte_ready;
    logic [31:0] pkt_data;
    logic        pkt_valid;
    logic        pkt_ready;
    logic        crc_err;
    logic [1:0]  err_cnt;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;
    logic saw_crc_err;

    always #5 clk = ~clk;

    crc8_packet_receiver #(.ERR_W(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_sof(byte_sof), .byte_ready(byte_ready), .pkt_data(pkt_data),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .crc_err(crc_err),
        .err_cnt(err_cnt), .timeout_err(timeout_err)
    );

    // Presents one byte for exactly one rising edge and returns 1 ns after that edge.
    task automatic send_byte(input logic [7:0] b, input logic s);
        @(negedge clk);
        byte_in = b; byte_valid = 1'b1; byte_sof = s;
        @(posedge clk); #1;
        byte_valid = 1'b0; byte_sof = 1'b0;
        if (crc_err === 1'b1) saw_crc_err = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; byte_sof = 1'b0; pkt_ready = 1'b1;
        #12;
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_byte_ready got=%0b exp=1", byte_ready); end
        checks++; if (pkt_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_pkt_valid got=%0b exp=0", pkt_valid); end
        checks++; if (pkt_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_pkt_data got=%h exp=0", pkt_data); end
        checks++; if (err_cnt !== 2'd0 || crc_err !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got cnt=%0d crc_err=%0b to=%0b exp 0/0/0", err_cnt, crc_err, timeout_err); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_good_frame;
        saw_crc_err = 1'b0;
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'hD5, 1'b0);
        checks++; if (pkt_valid !== 1'b1 || pkt_data !== 32'h0000_0001) begin errors++; $display("[TB] FAIL good_word got v=%0b d=%h exp v=1 d=00000001", pkt_valid, pkt_data); end
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("[TB] FAIL good_hold_ready got=%0b exp=0", byte_ready); end
        @(posedge clk); #1;
        checks++; if (pkt_valid !== 1'b0 || byte_ready !== 1'b1) begin errors++; $display("[TB] FAIL good_release got v=%0b rdy=%0b exp v=0 rdy=1", pkt_valid, byte_ready); end
        checks++; if (saw_crc_err !== 1'b0) begin errors++; $display("[TB] FAIL good_no_crc_err got=%0b exp=0", saw_crc_err); end
    endtask

    task automatic test_bad_crc;
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'hFF, 1'b0);
        send_byte(8'h00, 1'b0);
        checks++; if (crc_err !== 1'b1 || err_cnt !== 2'd1) begin errors++; $display("[TB] FAIL bad_crc_pulse got err=%0b cnt=%0d exp err=1 cnt=1", crc_err, err_cnt); end
        checks++; if (pkt_valid !== 1'b0 || byte_ready !== 1'b1) begin errors++; $display("[TB] FAIL bad_crc_no_word got v=%0b rdy=%0b exp v=0 rdy=1", pkt_valid, byte_ready); end
        @(posedge clk); #1;
        checks++; if (crc_err !== 1'b0) begin errors++; $display("[TB] FAIL bad_crc_one_cycle got=%0b exp=0", crc_err); end
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'hFF, 1'b0);
        send_byte(8'hF9, 1'b0);
        checks++; if (pkt_valid !== 1'b1 || pkt_data !== 32'h0000_00FF) begin errors++; $display("[TB] FAIL bad_then_good got v=%0b d=%h exp v=1 d=000000FF", pkt_valid, pkt_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        pkt_ready = 1'b0;
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'hFE, 1'b0);
        send_byte(8'h2C, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); byte_in = 8'hAA; byte_valid = 1'b1; byte_sof = 1'b1;
            @(posedge clk); #1;
            checks++; if (pkt_valid !== 1'b1 || pkt_data !== 32'h0000_00FE || byte_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold[%0d] got v=%0b d=%h rdy=%0b exp v=1 d=000000FE rdy=0", i, pkt_valid, pkt_data, byte_ready); end
        end
        @(negedge clk); byte_valid = 1'b0; byte_sof = 1'b0; pkt_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (pkt_valid !== 1'b0 || byte_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release got v=%0b rdy=%0b exp v=0 rdy=1", pkt_valid, byte_ready); end
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'hD5, 1'b0);
        checks++; if (pkt_valid !== 1'b1 || pkt_data !== 32'h0000_0001) begin errors++; $display("[TB] FAIL bp_after got v=%0b d=%h exp v=1 d=00000001", pkt_valid, pkt_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_resync;
        saw_crc_err = 1'b0;
        send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b0);
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'hD5, 1'b0);
        checks++; if (pkt_valid !== 1'b1 || pkt_data !== 32'h0000_0001) begin errors++; $display("[TB] FAIL resync_word got v=%0b d=%h exp v=1 d=00000001", pkt_valid, pkt_data); end
        @(posedge clk); #1;
        // sof arriving where the CRC byte was due restarts the frame instead of being checked
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'hD5, 1'b0);
        checks++; if (pkt_valid !== 1'b1 || pkt_data !== 32'h0000_0001) begin errors++; $display("[TB] FAIL resync_sof_at_crc got v=%0b d=%h exp v=1 d=00000001", pkt_valid, pkt_data); end
        checks++; if (saw_crc_err !== 1'b0) begin errors++; $display("[TB] FAIL resync_no_crc_err got=%0b exp=0", saw_crc_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation;
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'hFF, 1'b0);
            send_byte(8'h00, 1'b0);
            checks++; if (err_cnt !== exp_cnt[i] || crc_err !== 1'b1) begin errors++; $display("[TB] FAIL sat[%0d] got cnt=%0d err=%0b exp cnt=%0d err=1", i, err_cnt, crc_err, exp_cnt[i]); end
        end
    endtask

    task automatic test_timeout;
        logic seen;
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b0);
`ifdef RX_TIMEOUT_EN
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            checks++; if (timeout_err !== (i == 8)) begin errors++; $display("[TB] FAIL timeout_idle[%0d] got=%0b exp=%0b", i, timeout_err, (i == 8)); end
        end
        @(posedge clk); #1;
        checks++; if (timeout_err !== 1'b0 || err_cnt !== 2'd3) begin errors++; $display("[TB] FAIL timeout_after got to=%0b cnt=%0d exp to=0 cnt=3", timeout_err, err_cnt); end
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'hD5, 1'b0);
`else
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (timeout_err !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL no_timeout_pulse got=%0b exp=0", seen); end
        send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'hD5, 1'b0);
`endif
        checks++; if (pkt_valid !== 1'b1 || pkt_data !== 32'h0000_0001) begin errors++; $display("[TB] FAIL timeout_word got v=%0b d=%h exp v=1 d=00000001", pkt_valid, pkt_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_frame;
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b0);
        @(negedge clk); rst_n = 1'b0; #1;
        checks++; if (byte_ready !== 1'b1 || pkt_valid !== 1'b0 || pkt_data !== 32'h0 || err_cnt !== 2'd0 || crc_err !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid got rdy=%0b v=%0b d=%h cnt=%0d err=%0b to=%0b exp 1/0/0/0/0/0", byte_ready, pkt_valid, pkt_data, err_cnt, crc_err, timeout_err); end
        @(negedge clk); rst_n = 1'b1;
        // a byte counter left at 2 would treat the third byte below as the CRC byte
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'hD5, 1'b0);
        checks++; if (pkt_valid !== 1'b0 || err_cnt !== 2'd0) begin errors++; $display("[TB] FAIL rst_mid_partial got v=%0b cnt=%0d exp v=0 cnt=0", pkt_valid, err_cnt); end
        pkt_ready = 1'b0;
        send_byte(8'h00, 1'b0);
        checks++; if (pkt_valid !== 1'b1 || pkt_data !== 32'h0000_01D5) begin errors++; $display("[TB] FAIL rst_mid_word got v=%0b d=%h exp v=1 d=000001D5", pkt_valid, pkt_data); end
        #2; rst_n = 1'b0; #1;
        checks++; if (pkt_valid !== 1'b0 || pkt_data !== 32'h0 || byte_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_hold got v=%0b d=%h rdy=%0b exp v=0 d=0 rdy=1", pkt_valid, pkt_data, byte_ready); end
        @(negedge clk); rst_n = 1'b1; pkt_ready = 1'b1;
    endtask

    initial begin
        saw_crc_err = 1'b0;
        test_reset;
        test_good_frame;
        test_bad_crc;
        test_backpressure;
        test_resync;
        test_saturation;
        test_timeout;
        test_reset_mid_frame;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
